pipe_buf_stage: RTL
===================

# pipe_buf_stage

Parametrised pipeline buffer stage that replaces the fixed-width, always-advancing IF/ID, ID/EX, EX/MEM and MEM/WB registers with one generic block. It carries any packed stage struct as an opaque WIDTH-bit payload. It adds a valid/ready handshake for stalls, a flush for branch/jump squashing, and an optional two-entry skid buffer that registers the upstream ready path. It sits between every pair of pipeline stages in the datapath and is instantiated once per boundary.

## Interface
- WIDTH, 64, payload width in bits; set to $bits of the stage struct.
- FLUSH_VAL, '0, payload value loaded into every storage entry on reset or flush (NOP bubble).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash all held entries this cycle.
- in_valid  in  1  upstream stage presents a payload.
- in_ready  out  1  stage will accept a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid payload.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  WIDTH  oldest held payload.
- occupancy  out  2  number of valid entries held (0..2).
- bubble_cnt  out  16  saturating count of cycles with out_valid=0.

## Operation
- Accept = in_valid & in_ready. Emit = out_valid & out_ready. Payloads leave in arrival order; none are duplicated or dropped except by flush.
- Storage: main entry (drives out_data) and skid entry (SKID=1 only).
- SKID=1 states: EMPTY (occ 0), ONE (occ 1), TWO (occ 2). in_ready = (state != TWO), driven from a register.
  - EMPTY: accept -> ONE, main=in_data. No accept -> EMPTY.
  - ONE: accept & !emit -> TWO, skid=in_data. !accept & emit -> EMPTY. accept & emit -> ONE, main=in_data. Neither -> ONE.
  - TWO: emit -> ONE, main=skid. No emit -> TWO. Accept is impossible.
- SKID=0: single entry. in_ready = !out_valid | out_ready, combinational. Accept loads main and sets valid. Emit without accept clears valid. Occupancy is 0 or 1.
- out_valid = occupancy != 0. out_data = main, and equals FLUSH_VAL when empty.
- flush: next state EMPTY, and main and skid load FLUSH_VAL. This takes priority over any accept or emit in the same cycle. A payload offered during flush is discarded, even though in_ready may read 1. The emit handshake in that cycle still completes for the downstream consumer.
- reset: same effect as flush, and also clears bubble_cnt. Reset has priority over flush.
- bubble_cnt: increments on every cycle after the reset cycle in which out_valid=0. It saturates at 16'hFFFF and is cleared only by reset.

## Timing
- Reset values: out_valid=0, out_data=FLUSH_VAL, occupancy=0, bubble_cnt=0. in_ready=1 in the cycle after reset deasserts. in_ready may be 1 during reset itself, but any accept in that cycle is discarded.
- Latency: a payload accepted at edge N appears on out_data/out_valid after edge N (1 cycle) when the stage was empty or emitting.
- Throughput: one payload per cycle sustained when out_ready=1, for both SKID values.
- SKID=1: in_ready deasserts the cycle after the second entry fills. No combinational path runs from out_ready to in_ready.
- SKID=0: a combinational path from out_ready to in_ready exists. This is permitted only at boundaries without long ready chains.
- Flush at edge N: out_valid=0 from edge N, and the first new payload can be accepted in cycle N+1.
- Reset mid-stream: all held payloads are lost and no partial payload is emitted.

## Test plan
- Stream, SKID=1, WIDTH=32, out_ready=1: send 0x11,0x22,0x33 on consecutive cycles -> out_data shows 0x11,0x22,0x33 one cycle later each; occupancy stays 1; in_ready stays 1.
- Backpressure, SKID=1: out_ready=0, send 0xA,0xB,0xC -> occupancy 1 then 2; in_ready=0 after 0xB, so 0xC is held upstream. Release out_ready -> outputs 0xA,0xB,0xC in order with no loss.
- Flush with simultaneous accept, SKID=1, FLUSH_VAL=0x13: stage holds 2 entries, assert flush with in_valid=1, in_data=0x55 -> next cycle occupancy=0, out_valid=0, out_data=0x13, and 0x55 is never emitted.
- SKID=0 stall: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. Set out_ready=1 -> in_ready=1 combinationally, and the new payload replaces the old one in one edge.
- bubble_cnt: after reset hold in_valid=0 for 10 cycles -> bubble_cnt=10. Force 70000 idle cycles -> bubble_cnt=16'hFFFF. Then reset -> 0.
- Reset mid-operation: occupancy=2, assert reset one cycle -> occupancy=0, out_data=FLUSH_VAL, bubble_cnt=0, in_ready=1 the following cycle.

Source files
------------

// File: rtl/pipe_buf_stage.sv
// Generic pipeline boundary register with valid/ready handshake, flush, and
// an optional two-entry skid buffer that makes in_ready a registered signal.
module pipe_buf_stage #(
   parameter int unsigned      WIDTH     = 64,
   parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
   parameter bit               SKID      = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [15:0]      bubble_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   logic        w_accept;
   logic        w_emit;
   logic [15:0] r_bubble_cnt;

   assign w_accept   = in_valid & in_ready;
   assign w_emit     = out_valid & out_ready;
   assign bubble_cnt = r_bubble_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bubble_cnt <= 16'd0;
      end else if (!out_valid && (r_bubble_cnt != 16'hFFFF)) begin
         r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
   end

   if (SKID) begin : g_skid
      state_t           r_state;
      state_t           w_state_nxt;
      logic [WIDTH-1:0] r_main;
      logic [WIDTH-1:0] r_skid;
      logic [WIDTH-1:0] w_main_nxt;
      logic [WIDTH-1:0] w_skid_nxt;
      logic             r_in_ready;

      // Emptied entries are refilled with FLUSH_VAL so out_data reads as a bubble.
      always_comb begin
         w_state_nxt = r_state;
         w_main_nxt  = r_main;
         w_skid_nxt  = r_skid;
         if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = FLUSH_VAL;
            w_skid_nxt  = FLUSH_VAL;
         end else begin
            case (r_state)
               ST_EMPTY: begin
                  if (w_accept) begin
                     w_state_nxt = ST_ONE;
                     w_main_nxt  = in_data;
                  end
               end
               ST_ONE: begin
                  if (w_accept && !w_emit) begin
                     w_state_nxt = ST_TWO;
                     w_skid_nxt  = in_data;
                  end else if (!w_accept && w_emit) begin
                     w_state_nxt = ST_EMPTY;
                     w_main_nxt  = FLUSH_VAL;
                  end else if (w_accept && w_emit) begin
                     w_main_nxt  = in_data;
                  end
               end
               ST_TWO: begin
                  if (w_emit) begin
                     w_state_nxt = ST_ONE;
                     w_main_nxt  = r_skid;
                     w_skid_nxt  = FLUSH_VAL;
                  end
               end
               default: begin
                  w_state_nxt = ST_EMPTY;
                  w_main_nxt  = FLUSH_VAL;
                  w_skid_nxt  = FLUSH_VAL;
               end
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            r_state    <= ST_EMPTY;
            r_main     <= FLUSH_VAL;
            r_skid     <= FLUSH_VAL;
            r_in_ready <= 1'b1;
         end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
         end
      end

      assign in_ready  = r_in_ready;
      assign out_valid = (r_state != ST_EMPTY);
      assign out_data  = r_main;
      assign occupancy = (r_state == ST_TWO) ? 2'd2 :
                         (r_state == ST_ONE) ? 2'd1 : 2'd0;
   end else begin : g_single
      logic             r_valid;
      logic [WIDTH-1:0] r_main;

      always_ff @(posedge clk) begin
         if (reset || flush) begin
            r_valid <= 1'b0;
            r_main  <= FLUSH_VAL;
         end else if (w_accept) begin
            r_valid <= 1'b1;
            r_main  <= in_data;
         end else if (w_emit) begin
            r_valid <= 1'b0;
            r_main  <= FLUSH_VAL;
         end
      end

      // Combinational ready: a draining entry can be replaced in the same edge.
      assign in_ready  = !r_valid | out_ready;
      assign out_valid = r_valid;
      assign out_data  = r_main;
      assign occupancy = {1'b0, r_valid};
   end

endmodule
